// File: rtl/stepper_position_ctrl.sv
// Absolute-target full-step sequencer for a 4-wire stepper; one step per STEP_DIV cycles, then settle and pulse done.
// Commands accepted only in IDLE (cmd_ready); requester holds cmd_valid while busy. Coils registered, one cycle behind phase.
module stepper_position_ctrl #(
  parameter int STEP_DIV   = 100000,
  parameter int SETTLE_CYC = 250000,
  parameter int POS_W      = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  input  logic signed [POS_W-1:0] cmd_target,
  output logic                    cmd_ready,
  input  logic                    abort,
  input  logic                    zero_pos,
  input  logic                    hold_en,
  output logic [3:0]              coils,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    done
);

  localparam int TMR_W = $clog2(STEP_DIV);
  localparam int SET_W = $clog2(SETTLE_CYC + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic signed [POS_W-1:0]   pos_q, pos_d;
  logic signed [POS_W-1:0]   target_q, target_d;
  logic [1:0]                phase_q, phase_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic [SET_W-1:0]          settle_q, settle_d;
  logic [3:0]                coils_q, coils_d;
  logic [POS_W:0]            diff;

  function automatic logic [3:0] coil_tbl(input logic [1:0] ph);
    case (ph)
      2'd0:    coil_tbl = 4'b1100;
      2'd1:    coil_tbl = 4'b0110;
      2'd2:    coil_tbl = 4'b0011;
      default: coil_tbl = 4'b1001;
    endcase
  endfunction

  // Sign-extended subtraction: the sign bit gives direction even at range extremes.
  assign diff = {target_q[POS_W-1], target_q} - {pos_q[POS_W-1], pos_q};

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;
    phase_d  = phase_q;
    timer_d  = timer_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          target_d = cmd_target;
          timer_d  = '0;
          state_d  = (cmd_target == pos_q) ? DONE : MOVE;
        end else if (zero_pos) begin
          pos_d = '0;
        end
      end
      MOVE: begin
        if (abort) begin
          state_d  = DONE;
          target_d = pos_q;
        end else if (timer_q == TMR_W'(STEP_DIV - 1)) begin
          timer_d = '0;
          if (!diff[POS_W]) begin
            pos_d   = pos_q + POS_W'(1);
            phase_d = phase_q + 2'd1;
          end else begin
            pos_d   = pos_q - POS_W'(1);
            phase_d = phase_q - 2'd1;
          end
          if (pos_d == target_q) begin
            state_d  = SETTLE;
            settle_d = '0;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d  = DONE;
          target_d = pos_q;
        end else if (settle_q == SET_W'(SETTLE_CYC)) begin
          state_d = DONE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coils_d = 4'b0000;
    if (state_q == MOVE || state_q == SETTLE || hold_en) coils_d = coil_tbl(phase_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      target_q <= '0;
      phase_q  <= 2'd0;
      timer_q  <= '0;
      settle_q <= '0;
      coils_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      phase_q  <= phase_d;
      timer_q  <= timer_d;
      settle_q <= settle_d;
      coils_q  <= coils_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == MOVE) || (state_q == SETTLE);
  assign done      = (state_q == DONE);
  assign position  = pos_q;
  assign coils     = coils_q;

endmodule

// File: tb/tb_stepper_position_ctrl.sv
// Bench for stepper_position_ctrl with STEP_DIV=4, SETTLE_CYC=3; expected steps queued per command and popped as the DUT steps.
module tb_stepper_position_ctrl;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic signed [15:0] cmd_target = '0;
  logic               cmd_ready;
  logic               abort = 1'b0;
  logic               zero_pos = 1'b0;
  logic               hold_en = 1'b0;
  logic [3:0]         coils;
  logic signed [15:0] position;
  logic               busy;
  logic               done;

  int errors = 0;
  int checks = 0;

  // Reference model state and scoreboard
  int                 m_pos = 0;
  int                 m_ph  = 0;
  logic signed [15:0] exp_pos[$];
  logic [3:0]         exp_coil[$];
  int                 exp_cyc[$];

  stepper_position_ctrl #(.STEP_DIV(4), .SETTLE_CYC(3), .POS_W(16)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_target(cmd_target),
    .cmd_ready(cmd_ready), .abort(abort), .zero_pos(zero_pos), .hold_en(hold_en),
    .coils(coils), .position(position), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] tbl(input int ph);
    case (ph)
      0:       return 4'b1100;
      1:       return 4'b0110;
      2:       return 4'b0011;
      default: return 4'b1001;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_move(input int tgt, input string tag);
    int n = 0;
    int k = 0;
    int exp_done;
    bit done_seen = 0;
    bit pend_v = 0;
    logic [3:0] pend;
    logic signed [15:0] prev;
    logic signed [15:0] ep;
    int ec;
    while (m_pos != tgt) begin
      if (tgt > m_pos) begin m_pos++; m_ph = (m_ph + 1) % 4; end
      else begin m_pos--; m_ph = (m_ph + 3) % 4; end
      n++;
      exp_pos.push_back(16'(m_pos));
      exp_coil.push_back(tbl(m_ph));
      exp_cyc.push_back(4 * n);
    end
    exp_done = (n == 0) ? 0 : 4 * n + 4;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s ready_before: got %b want 1", tag, cmd_ready); end
    prev = position;
    cmd_valid = 1'b1; cmd_target = 16'(tgt);
    tick();
    cmd_valid = 1'b0;
    while (!done_seen && k < 300) begin
      if (pend_v) begin
        checks++;
        if (coils !== pend) begin errors++; $display("FAIL %s coils@%0d: got %b want %b", tag, k, coils, pend); end
        pend_v = 0;
      end
      if (position !== prev) begin
        checks++;
        if (exp_pos.size() == 0) begin
          errors++; $display("FAIL %s extra_step@%0d: got pos %0d want none", tag, k, position);
        end else begin
          ep = exp_pos.pop_front(); pend = exp_coil.pop_front(); ec = exp_cyc.pop_front();
          pend_v = 1;
          if (position !== ep || k != ec) begin
            errors++; $display("FAIL %s step: got pos %0d at %0d want pos %0d at %0d", tag, position, k, ep, ec);
          end
        end
        prev = position;
      end
      if (done === 1'b1) begin
        done_seen = 1;
        checks++;
        if (k != exp_done || exp_pos.size() != 0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s done: got cyc %0d left %0d busy %b rdy %b want cyc %0d left 0 busy 0 rdy 0",
                   tag, k, exp_pos.size(), busy, cmd_ready, exp_done);
        end
      end else begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy@%0d: got %b want 1", tag, k, busy); end
        tick();
        k++;
      end
    end
    if (!done_seen) begin
      errors++; $display("FAIL %s timeout: got no done want done at %0d", tag, exp_done);
    end
    exp_pos.delete(); exp_coil.delete(); exp_cyc.delete();
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || position !== 16'(m_pos) ||
        coils !== (hold_en ? tbl(m_ph) : 4'b0000)) begin
      errors++;
      $display("FAIL %s after: got done %b rdy %b busy %b pos %0d coils %b want 0 1 0 %0d %b",
               tag, done, cmd_ready, busy, position, coils, m_pos, hold_en ? tbl(m_ph) : 4'b0000);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (coils !== 4'b0000 || position !== 16'sd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got coils %b pos %0d rdy %b busy %b done %b want 0000 0 1 0 0", coils, position, cmd_ready, busy, done);
    end
    reset = 1'b0;
    m_pos = 0; m_ph = 0;
    tick();
  endtask

  task automatic test_forward();
    run_move(5, "fwd");
  endtask

  task automatic test_reverse();
    run_move(-2, "rev");
  endtask

  task automatic test_zero();
    run_move(-2, "zero_len");
    zero_pos = 1'b1;
    tick();
    zero_pos = 1'b0;
    m_pos = 0;
    checks++;
    if (position !== 16'sd0) begin errors++; $display("FAIL zero_pos: got %0d want 0", position); end
    hold_en = 1'b1;
    tick();
    checks++;
    if (coils !== tbl(m_ph)) begin errors++; $display("FAIL zero_phase: got %b want %b", coils, tbl(m_ph)); end
    hold_en = 1'b0;
    tick();
    run_move(3, "to3");
    cmd_valid = 1'b1; zero_pos = 1'b1; cmd_target = 16'sd3;
    tick();
    cmd_valid = 1'b0; zero_pos = 1'b0;
    checks++;
    if (done !== 1'b1 || position !== 16'sd3) begin
      errors++; $display("FAIL cmd_vs_zero: got done %b pos %0d want 1 3", done, position);
    end
    tick();
    checks++;
    if (position !== 16'sd3 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_vs_zero_after: got pos %0d rdy %b want 3 1", position, cmd_ready);
    end
  endtask

  task automatic test_abort();
    zero_pos = 1'b1;
    tick();
    zero_pos = 1'b0;
    m_pos = 0;
    cmd_valid = 1'b1; cmd_target = 16'sd10;
    tick();
    cmd_valid = 1'b0;
    repeat (11) tick();
    checks++;
    if (position !== 16'sd2 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre: got pos %0d busy %b want 2 1", position, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m_pos = 2; m_ph = (m_ph + 2) % 4;
    checks++;
    if (done !== 1'b1 || position !== 16'sd2 || busy !== 1'b0) begin
      errors++; $display("FAIL abort: got done %b pos %0d busy %b want 1 2 0", done, position, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || position !== 16'sd2) begin
      errors++; $display("FAIL abort_after: got done %b rdy %b pos %0d want 0 1 2", done, cmd_ready, position);
    end
    run_move(2, "post_abort");
  endtask

  task automatic test_async_reset();
    cmd_valid = 1'b1; cmd_target = 16'sd8;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (coils !== 4'b0000 || busy !== 1'b0 || position !== 16'sd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got coils %b busy %b pos %0d rdy %b want 0000 0 0 1", coils, busy, position, cmd_ready);
    end
    hold_en = 1'b1;
    tick();
    reset = 1'b0;
    m_pos = 0; m_ph = 0;
    tick();
    checks++;
    if (coils !== 4'b1100 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_idle: got coils %b busy %b want 1100 0", coils, busy);
    end
    run_move(1, "hold_move");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_zero();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
